// File: rtl/regfile_read_encoder.sv
// One-hot read select encoder with write bypass, returning register data through
// a single-entry valid/ready response register and counting malformed selects.
module regfile_read_encoder #(
  parameter int WIDTH = 32,
  parameter int NREG  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH*NREG-1:0] regs_flat,
  input  logic                  wr_en,
  input  logic [7:0]            wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [2:0]            rsp_idx,
  output logic                  rsp_err,
  output logic [7:0]            err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_r, state_next_s;
  logic             accept_s;
  logic [2:0]       enc_idx_s;
  logic             enc_err_s;
  logic             wr_hit_s;
  logic [WIDTH-1:0] sel_data_s;
  logic [WIDTH-1:0] rsp_data_r;
  logic [2:0]       rsp_idx_r;
  logic             rsp_err_r;
  logic [7:0]       err_count_r;

  // Lowest set bit wins so multi-hot selects still resolve deterministically.
  function automatic logic [2:0] lowest_set(input logic [7:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (sel[i]) idx = 3'(i);
      else        idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [3:0] count_ones(input logic [7:0] sel);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, sel[i]};
    return n;
  endfunction

  assign rsp_valid = (state_r == FULL);
  assign req_ready = !rsp_valid | rsp_ready;
  assign accept_s  = req_valid & req_ready;
  assign enc_idx_s = lowest_set(req_sel);
  assign enc_err_s = (count_ones(req_sel) != 4'd1);
  assign wr_hit_s  = wr_en & wr_sel[enc_idx_s];

  // Capture-data select: zero select reads as 0, a coincident write overrides storage.
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    if (req_sel == 8'd0) begin
      sel_data_s = {WIDTH{1'b0}};
    end else if (wr_hit_s) begin
      sel_data_s = wr_data;
    end else begin
      sel_data_s = regs_flat[int'(enc_idx_s)*WIDTH +: WIDTH];
    end
  end

  // Next-state logic for the single response slot.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_next_s = FULL;
        else          state_next_s = EMPTY;
      end
      FULL: begin
        if (rsp_ready && !accept_s) state_next_s = EMPTY;
        else                        state_next_s = FULL;
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= EMPTY;
    else        state_r <= state_next_s;
  end

  // Response payload loads only on acceptance, so a stalled response is a snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_idx_r  <= 3'd0;
      rsp_err_r  <= 1'b0;
    end else if (accept_s) begin
      rsp_data_r <= sel_data_s;
      rsp_idx_r  <= enc_idx_s;
      rsp_err_r  <= enc_err_s;
    end else begin
      rsp_data_r <= rsp_data_r;
      rsp_idx_r  <= rsp_idx_r;
      rsp_err_r  <= rsp_err_r;
    end
  end

  // Saturating count of accepted malformed requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 8'd0;
    end else if (accept_s && enc_err_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign rsp_data  = rsp_data_r;
  assign rsp_idx   = rsp_idx_r;
  assign rsp_err   = rsp_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_regfile_read_encoder.sv
// Directed bench for regfile_read_encoder: a queue scoreboard of expected responses
// plus direct checks on ready, stall, error-count and reset behaviour.
module tb_regfile_read_encoder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH*8-1:0] regs_flat;
  logic             wr_en;
  logic [7:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_idx;
  logic             rsp_err;
  logic [7:0]       err_count;

  logic [WIDTH-1:0] regs_m [8];
  logic [35:0]      sb_q [$];
  int               checks = 0;
  int               errors = 0;

  regfile_read_encoder #(.WIDTH(WIDTH), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .regs_flat(regs_flat),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_idx(rsp_idx), .rsp_err(rsp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_flat();
    for (int i = 0; i < 8; i++) regs_flat[i*WIDTH +: WIDTH] = regs_m[i];
  endtask

  // Reference response {err, idx, data} for a request accepted with the current inputs.
  function automatic logic [35:0] model(input logic [7:0] sel);
    logic [2:0]       idx;
    logic [WIDTH-1:0] data;
    logic             err;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (sel[i]) idx = 3'(i);
    err = ($countones(sel) != 1);
    if (sel == 8'd0)             data = '0;
    else if (wr_en && wr_sel[idx]) data = wr_data;
    else                         data = regs_m[idx];
    return {err,idx, data};
  endfunction

  // One clock: score consume/accept at the current inputs, then advance past the edge.
  task automatic step();
    logic [35:0] e;
    #1;
    if (rsp_valid && rsp_ready) begin
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_data", 64'(rsp_data), 64'(e[31:0]));
        chk("sb_idx",  64'(rsp_idx),  64'(e[34:32]));
        chk("sb_err",  64'(rsp_err),  64'(e[35]));
      end
    end
    if (req_valid && req_ready) sb_q.push_back(model(req_sel));
    @(posedge clk);
    #1;
    if (wr_en) begin
      for (int i = 0; i < 8; i++) if (wr_sel[i]) regs_m[i] = wr_data;
      sync_flat();
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 8'd0; wr_data = '0;
    req_valid = 1'b0; req_sel = 8'd0; rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) regs_m[i] = '0;
    sync_flat();
    #12;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data",  64'(rsp_data),  64'd0);
    chk("rst_idx",   64'(rsp_idx),   64'd0);
    chk("rst_err",   64'(rsp_err),   64'd0);
    chk("rst_cnt",   64'(err_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain read of reg3
    regs_m[3] = 32'hDEADBEEF; sync_flat();
    req_valid = 1'b1; req_sel = 8'b0000_1000; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("rd3_valid", 64'(rsp_valid), 64'd1);
    chk("rd3_idx",   64'(rsp_idx),   64'd3);
    chk("rd3_data",  64'(rsp_data),  64'hDEADBEEF);
    chk("rd3_err",   64'(rsp_err),   64'd0);
    step();

    // Same-cycle write bypass to reg5
    req_valid = 1'b1; req_sel = 8'b0010_0000;
    wr_en = 1'b1; wr_sel = 8'b0010_0000; wr_data = 32'h12345678;
    step();
    wr_en = 1'b0; req_valid = 1'b0;
    chk("byp_data", 64'(rsp_data), 64'h12345678);
    step();

    // Back-to-back sweep of all registers
    for (int i = 0; i < 8; i++) regs_m[i] = 32'h1000_0000 + 32'(i);
    sync_flat();
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_sel = 8'd1 << i;
      #1 chk("b2b_ready", 64'(req_ready), 64'd1);
      step();
      chk("b2b_valid", 64'(rsp_valid), 64'd1);
      chk("b2b_idx",   64'(rsp_idx),   64'(i));
    end
    req_valid = 1'b0;
    step();
    chk("b2b_drain", 64'(rsp_valid), 64'd0);

    // Stall with a write to the held register
    regs_m[2] = 32'hA; sync_flat();
    req_valid = 1'b1; req_sel = 8'b0000_0100;
    step();
    req_sel = 8'b0000_0010; rsp_ready = 1'b0;
    wr_en = 1'b1; wr_sel = 8'b0000_0100; wr_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_ready", 64'(req_ready), 64'd0);
      step();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data",  64'(rsp_data),  64'hA);
      chk("stall_idx",   64'(rsp_idx),   64'd2);
    end
    wr_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("stall_consumed", 64'(rsp_valid), 64'd0);

    // Malformed selects
    req_valid = 1'b1; req_sel = 8'd0;
    step();
    chk("zero_err",  64'(rsp_err),   64'd1);
    chk("zero_idx",  64'(rsp_idx),   64'd0);
    chk("zero_data", 64'(rsp_data),  64'd0);
    chk("zero_cnt",  64'(err_count), 64'd1);
    req_sel = 8'b0100_0100;
    step();
    chk("multi_idx",  64'(rsp_idx),   64'd2);
    chk("multi_data", 64'(rsp_data),  64'hB);
    chk("multi_err",  64'(rsp_err),   64'd1);
    chk("multi_cnt",  64'(err_count), 64'd2);

    // Saturation
    req_sel = 8'b0000_0011;
    for (int k = 0; k < 300; k++) begin
      step();
      if (k == 100) chk("cnt_mid", 64'(err_count), 64'd103);
    end
    chk("cnt_sat", 64'(err_count), 64'd255);
    req_valid = 1'b0;
    step();

    // Hold a response, then reset asynchronously between edges
    rsp_ready = 1'b0; req_valid = 1'b1; req_sel = 8'b0000_0001;
    step();
    req_valid = 1'b0;
    chk("hold_valid", 64'(rsp_valid), 64'd1);
    chk("sb_pending", 64'(sb_q.size()), 64'd1);
    void'(sb_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_cnt",   64'(err_count), 64'd0);
    chk("arst_data",  64'(rsp_data),  64'd0);
    chk("sb_empty",   64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_read_encoder.md
# regfile_read_encoder

Read-side counterpart to the register file's one-hot write-enable decoder. Accepts a one-hot register select, encodes it to a binary index, muxes the selected register out of the flattened register bus, and returns the data through a single-stage valid/ready pipeline register. Also bypasses same-cycle writes and counts malformed selects. Sits between the register storage array and any read consumer, such as the ALU operand fetch.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- NREG, 8, number of registers (fixed at 8; index width 3)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- regs_flat  input  WIDTH*8  current register contents; reg i = bits [i*WIDTH +: WIDTH]
- wr_en  input  1  write-port enable, same cycle as storage write
- wr_sel  input  8  one-hot write select from the write decoder
- wr_data  input  WIDTH  write data; visible on regs_flat only after the next edge
- req_valid  input  1  read request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- req_sel  input  8  one-hot read select
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer ready
- rsp_data  output  WIDTH  read data
- rsp_idx  output  3  binary index of the selected register
- rsp_err  output  1  request select was not exactly one-hot
- err_count  output  8  saturating count of accepted malformed requests

## Operation
- Encoding: rsp_idx = position of the lowest set bit of req_sel. rsp_err = (popcount(req_sel) != 1).
- req_sel == 0: idx 0, data 0, err 1.
- Multi-hot req_sel: idx and data come from the lowest set bit; err 1.
- Data: value of register rsp_idx from regs_flat, captured at acceptance.
- Bypass: if acceptance coincides with wr_en and wr_sel has the encoded index bit set, the captured data is wr_data instead of regs_flat.
  - The bypass also applies to a multi-hot wr_sel that includes that bit.
  - The bypass does not apply to a zero-select request.
- Snapshot rule: a held response is never updated by later writes, even to the same register, while stalled.
- err_count increments by 1 on each accepted request with rsp_err = 1. It saturates at 255 and clears only on reset.
- State: single response register, two states.
  - EMPTY (rsp_valid = 0): accepting a request moves to FULL.
  - FULL: rsp_ready with no new accept moves to EMPTY.
  - FULL: rsp_ready with a new accept stays FULL, loading the new response.
  - FULL: without rsp_ready, hold all outputs.

## Timing
- Reset (async assert, sync release by the surrounding design): rsp_valid 0, rsp_data 0, rsp_idx 0, rsp_err 0, err_count 0, state EMPTY.
- Reset asserted mid-transaction discards the held response immediately.
- req_ready = !rsp_valid | rsp_ready. It is combinational from rsp_ready and has no dependency on req_valid.
- Latency: 1 cycle. A request accepted at edge N has its response valid after edge N, until consumed.
- Throughput: 1 request per cycle when rsp_ready is held high.
- Stall: when rsp_valid & !rsp_ready, req_ready = 0 and rsp_data, rsp_idx and rsp_err hold stable.
- rsp_data, rsp_idx, rsp_err and rsp_valid are registered outputs with no combinational path from inputs.
- Simultaneous consume and accept on the same edge: the new response replaces the old one with no bubble. err_count updates on the same edge.

## Test plan
- Reset, then preload reg3 = 0xDEADBEEF, req_sel = 8'b0000_1000, rsp_ready = 1 -> the next cycle shows rsp_valid 1, rsp_idx 3, rsp_data 0xDEADBEEF, rsp_err 0.
- Request reg5 in the same cycle as wr_en = 1, wr_sel = 8'b0010_0000, wr_data = 0x12345678 (old reg5 = 0) -> rsp_data 0x12345678.
- Back-to-back requests to regs 0..7 with rsp_ready = 1 -> 8 responses on 8 consecutive cycles with idx 0..7, req_ready constantly 1.
- Accept a request for reg2 (value 0xA), hold rsp_ready = 0 for 4 cycles while writing reg2 = 0xB -> req_ready 0, rsp_data stays 0xA. Raising rsp_ready consumes it.
- req_sel = 0 -> rsp_err 1, idx 0, data 0, err_count 1. req_sel = 8'b0100_0100 -> idx 2, data of reg2, rsp_err 1, err_count 2.
- 300 malformed requests -> err_count saturates at 255. Assert rst_n low while a response is held -> rsp_valid and err_count go to 0 without waiting for a clock edge.
